// File: rtl/fg_pkg.sv
// fg_pkg: mode codes, FSM/op encodings and ASCII constants shared by the
// function-generator command interface.
package fg_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SINE   = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_WAIT,
        ST_NUM_ENTRY,
        ST_APPLY,
        ST_RESP
    } state_e;

    // Register update pending for the APPLY cycle
    typedef enum logic [3:0] {
        OP_NONE,
        OP_MODE,
        OP_DN,
        OP_UP,
        OP_HALF,
        OP_DBL,
        OP_RST,
        OP_SET,
        OP_SEL
    } op_e;

    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;

    localparam logic [7:0] CMD_SQUARE = 8'h73; // s
    localparam logic [7:0] CMD_SINE   = 8'h69; // i
    localparam logic [7:0] CMD_TRI    = 8'h74; // t
    localparam logic [7:0] CMD_SAW    = 8'h61; // a
    localparam logic [7:0] CMD_DN     = 8'h3D; // =
    localparam logic [7:0] CMD_UP     = 8'h2D; // -
    localparam logic [7:0] CMD_HALF   = 8'h75; // u
    localparam logic [7:0] CMD_DBL    = 8'h64; // d
    localparam logic [7:0] CMD_RST    = 8'h72; // r
    localparam logic [7:0] CMD_CH     = 8'h63; // c
    localparam logic [7:0] CMD_FREQ   = 8'h66; // f
    localparam logic [7:0] CMD_QUERY  = 8'h3F; // ?

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/fg_resp_tx.sv
// fg_resp_tx: serialises "K"/"E" [hex word] CR LF responses, one byte per
// new_tx_data pulse, only while tx_busy is low. Hex readback is built only
// when FG_READBACK_EN is defined.
module fg_resp_tx
    import fg_pkg::*;
#(
    parameter int unsigned FREQ_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_err,
`ifdef FG_READBACK_EN
    input  logic              rb,
    input  logic [FREQ_W-1:0] rb_word,
`endif
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    output logic              done
);

    localparam int unsigned NHEX = FREQ_W / 4;
    localparam int unsigned IW   = $clog2(NHEX + 3);

    logic          active_q, active_d;
    logic          gap_q, gap_d;
    logic          err_q, err_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] last_idx;
    logic          fire;
`ifdef FG_READBACK_EN
    logic              rb_q, rb_d;
    logic [FREQ_W-1:0] word_q, word_d;
`endif

    // The gap cycle after each byte gives the UART time to raise tx_busy
    assign fire        = active_q & ~gap_q & ~tx_busy;
    assign new_tx_data = fire;
    assign done        = fire && (idx_q == last_idx);

    // Select the byte at the current sequence position
    always_comb begin
`ifdef FG_READBACK_EN
        last_idx = rb_q ? IW'(NHEX + 2) : IW'(2);
`else
        last_idx = IW'(2);
`endif
        tx_data = '0;
        if (active_q) begin
            if (idx_q == '0)
                tx_data = err_q ? ASCII_E : ASCII_K;
            else if (idx_q == last_idx)
                tx_data = ASCII_LF;
            else if (idx_q == last_idx - 1'b1)
                tx_data = ASCII_CR;
`ifdef FG_READBACK_EN
            else
                tx_data = hex_ascii(word_q[FREQ_W-1 -: 4]);
`endif
        end
    end

    // Sequence advance: latch a new response on start, step on each byte sent
    always_comb begin
        active_d = active_q;
        gap_d    = 1'b0;
        err_d    = err_q;
        idx_d    = idx_q;
`ifdef FG_READBACK_EN
        rb_d     = rb_q;
        word_d   = word_q;
`endif
        if (start) begin
            active_d = 1'b1;
            idx_d    = '0;
            err_d    = is_err;
`ifdef FG_READBACK_EN
            rb_d     = rb & ~is_err;
            word_d   = rb_word;
`endif
        end else if (fire) begin
            gap_d = 1'b1;
            idx_d = idx_q + 1'b1;
            if (idx_q == last_idx)
                active_d = 1'b0;
`ifdef FG_READBACK_EN
            if (idx_q != '0)
                word_d = word_q << 4;
`endif
        end
    end

    // State registers; reset drops any response in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            gap_q    <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
`ifdef FG_READBACK_EN
            rb_q     <= 1'b0;
            word_q   <= '0;
`endif
        end else begin
            active_q <= active_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
`ifdef FG_READBACK_EN
            rb_q     <= rb_d;
            word_q   <= word_d;
`endif
        end
    end

endmodule

// File: rtl/fg_cmd_interface.sv
// fg_cmd_interface: UART command decoder and rotary-encoder control for a
// multi-channel function generator. Optional "?" hex readback: FG_READBACK_EN.
module fg_cmd_interface
    import fg_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FREQ_W     = 32,
    parameter int unsigned RESET_WORD = 2147483,
    parameter int unsigned DIGITS_MAX = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     new_rx_data,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy,
    input  logic                     enc_step,
    input  logic                     enc_dir,
    input  logic                     enc_press,
    output logic [NUM_CH*FREQ_W-1:0] freq,
    output logic [NUM_CH*2-1:0]      mode,
    output logic [1:0]               sel_ch
);

    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DW = $clog2(DIGITS_MAX + 1);
    localparam logic [FREQ_W-1:0] RST_W = FREQ_W'(RESET_WORD);
    localparam logic [FREQ_W-1:0] ONE   = FREQ_W'(1);
    localparam logic [7:0] CH_LIMIT     = 8'(ASCII_0 + NUM_CH);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [1:0]        arg_q, arg_d;
    logic              err_q, err_d;
    logic [FREQ_W-1:0] acc_q, acc_d;
    logic [DW-1:0]     ndig_q, ndig_d;
    logic [1:0]        sel_q, sel_d;
    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [FREQ_W-1:0] freq_d [NUM_CH];
    logic [1:0]        mode_q [NUM_CH];
    logic [1:0]        mode_d [NUM_CH];
`ifdef FG_READBACK_EN
    logic              rb_q, rb_d;
`endif
    logic [CW-1:0]     sel_idx;
    logic [FREQ_W+3:0] prod;
    logic              enc_block;
    logic              resp_done;

    function automatic logic [FREQ_W-1:0] step_of(input logic [FREQ_W-1:0] w);
        return ((w >> 4) == '0) ? ONE : (w >> 4);
    endfunction

    function automatic logic [FREQ_W-1:0] word_dn(input logic [FREQ_W-1:0] w);
        return (w > step_of(w)) ? (w - step_of(w)) : ONE;
    endfunction

    function automatic logic [FREQ_W-1:0] word_up(input logic [FREQ_W-1:0] w);
        logic [FREQ_W:0] s;
        s = {1'b0, w} + {1'b0, step_of(w)};
        return s[FREQ_W] ? '1 : s[FREQ_W-1:0];
    endfunction

    assign sel_idx = sel_q[CW-1:0];
    assign sel_ch  = sel_q;
    // acc*10 + digit, with four headroom bits to detect overflow
    assign prod = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                + {{FREQ_W{1'b0}}, rx_data[3:0]};
    assign enc_block = (state_q == ST_APPLY) && !err_q &&
                       (op_q inside {OP_MODE, OP_DN, OP_UP, OP_HALF, OP_DBL, OP_RST, OP_SET});

    // Flatten per-channel registers onto the output buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            freq[i*FREQ_W +: FREQ_W] = freq_q[i];
            mode[i*2 +: 2]           = mode_q[i];
        end
    end

    // Command FSM next state, APPLY-cycle register update, then encoder events
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        err_d   = err_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        sel_d   = sel_q;
        freq_d  = freq_q;
        mode_d  = mode_q;
`ifdef FG_READBACK_EN
        rb_d    = rb_q;
`endif
        case (state_q)
            ST_IDLE: if (new_rx_data) begin
                state_d = ST_APPLY;
                op_d    = OP_NONE;
                err_d   = 1'b0;
`ifdef FG_READBACK_EN
                rb_d    = 1'b0;
`endif
                case (rx_data)
                    CMD_SQUARE: begin op_d = OP_MODE; arg_d = MODE_SQUARE; end
                    CMD_SINE:   begin op_d = OP_MODE; arg_d = MODE_SINE;   end
                    CMD_TRI:    begin op_d = OP_MODE; arg_d = MODE_TRI;    end
                    CMD_SAW:    begin op_d = OP_MODE; arg_d = MODE_SAW;    end
                    CMD_DN:     op_d = OP_DN;
                    CMD_UP:     op_d = OP_UP;
                    CMD_HALF:   op_d = OP_HALF;
                    CMD_DBL:    op_d = OP_DBL;
                    CMD_RST:    op_d = OP_RST;
                    CMD_CH:     state_d = ST_CH_WAIT;
                    CMD_FREQ: begin
                        state_d = ST_NUM_ENTRY;
                        acc_d   = '0;
                        ndig_d  = '0;
                    end
`ifdef FG_READBACK_EN
                    CMD_QUERY:  rb_d = 1'b1;
`endif
                    default:    err_d = 1'b1;
                endcase
            end
            ST_CH_WAIT: if (new_rx_data) begin
                state_d = ST_APPLY;
                if (rx_data >= ASCII_0 && rx_data < CH_LIMIT) begin
                    op_d  = OP_SEL;
                    arg_d = rx_data[1:0];
                end else begin
                    err_d = 1'b1;
                end
            end
            // Overflow and digit-count errors are sticky and reported at CR
            ST_NUM_ENTRY: if (new_rx_data) begin
                if (rx_data >= ASCII_0 && rx_data <= ASCII_9) begin
                    if (ndig_q == DW'(DIGITS_MAX))
                        err_d = 1'b1;
                    else if (prod[FREQ_W+3:FREQ_W] != '0)
                        err_d = 1'b1;
                    else
                        acc_d = prod[FREQ_W-1:0];
                    if (ndig_q != DW'(DIGITS_MAX))
                        ndig_d = ndig_q + 1'b1;
                end else if (rx_data == ASCII_CR) begin
                    state_d = ST_APPLY;
                    op_d    = OP_SET;
                    if (acc_q == '0)
                        err_d = 1'b1;
                end else begin
                    state_d = ST_APPLY;
                    op_d    = OP_NONE;
                    err_d   = 1'b1;
                end
            end
            ST_APPLY: begin
                state_d = ST_RESP;
                if (!err_q) begin
                    case (op_q)
                        OP_MODE: mode_d[sel_idx] = arg_q;
                        OP_DN:   freq_d[sel_idx] = word_dn(freq_q[sel_idx]);
                        OP_UP:   freq_d[sel_idx] = word_up(freq_q[sel_idx]);
                        OP_HALF: freq_d[sel_idx] = ((freq_q[sel_idx] >> 1) == '0) ? ONE : (freq_q[sel_idx] >> 1);
                        OP_DBL:  freq_d[sel_idx] = freq_q[sel_idx][FREQ_W-1] ? '1 : (freq_q[sel_idx] << 1);
                        OP_RST:  freq_d[sel_idx] = RST_W;
                        OP_SET:  freq_d[sel_idx] = acc_q;
                        OP_SEL:  sel_d = arg_q;
                        default: ;
                    endcase
                end
            end
            ST_RESP: if (resp_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Serial command wins over an encoder event landing on its APPLY cycle
        if (!enc_block) begin
            if (enc_step)
                freq_d[sel_idx] = enc_dir ? word_dn(freq_q[sel_idx]) : word_up(freq_q[sel_idx]);
            if (enc_press)
                mode_d[sel_idx] = mode_q[sel_idx] + 2'd1;
        end
    end

    // Register all FSM and channel state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            arg_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            ndig_q  <= '0;
            sel_q   <= '0;
`ifdef FG_READBACK_EN
            rb_q    <= 1'b0;
`endif
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                freq_q[i] <= RST_W;
                mode_q[i] <= MODE_SQUARE;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            sel_q   <= sel_d;
`ifdef FG_READBACK_EN
            rb_q    <= rb_d;
`endif
            freq_q  <= freq_d;
            mode_q  <= mode_d;
        end
    end

    fg_resp_tx #(
        .FREQ_W (FREQ_W)
    ) u_resp_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (state_q == ST_APPLY),
        .is_err      (err_q),
`ifdef FG_READBACK_EN
        .rb          (rb_q),
        .rb_word     (freq_q[sel_idx]),
`endif
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .done        (resp_done)
    );

endmodule

// File: tb/tb_fg_cmd_interface.sv
// tb_fg_cmd_interface: directed command/encoder vectors with hand-computed
// expectations; a small UART model collects response bytes and drives tx_busy.
`timescale 1ns/1ps
module tb_fg_cmd_interface;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned FREQ_W = 32;
    localparam logic [31:0] RW     = 32'd2147483;   // 0x0020C49B

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic        enc_step, enc_dir, enc_press;
    logic [63:0] freq;
    logic [3:0]  mode;
    logic [1:0]  sel_ch;

    int          n_total = 0;
    int          n_bad   = 0;
    int          busy_cycles = 2;
    logic [7:0]  got_q[$];

    always #5 clk = ~clk;

    fg_cmd_interface #(
        .NUM_CH     (NUM_CH),
        .FREQ_W     (FREQ_W),
        .RESET_WORD (2147483),
        .DIGITS_MAX (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .enc_step    (enc_step),
        .enc_dir     (enc_dir),
        .enc_press   (enc_press),
        .freq        (freq),
        .mode        (mode),
        .sel_ch      (sel_ch)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // UART model: record each strobed byte, then hold tx_busy for busy_cycles
    initial begin : uart_model
        logic seen;
        int   cnt;
        cnt     = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            seen = new_tx_data;
            if (seen) begin
                check_eq("strobe_busy", 64'(tx_busy), 64'd0);
                got_q.push_back(tx_data);
            end
            @(posedge clk);
            #1;
            if (seen && busy_cycles > 0) begin
                tx_busy = 1'b1;
                cnt     = busy_cycles;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Expect <first byte(s)> CR LF, bounded wait
    task automatic expect_resp(input string tag, input string s);
        int budget;
        int n;
        budget = 600;
        n = s.len() + 2;
        while (got_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq({tag, "_len"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] b, e;
            b = (got_q.size() > 0) ? got_q.pop_front() : 8'h00;
            e = (i < s.len()) ? s[i] : ((i == s.len()) ? 8'h0D : 8'h0A);
            check_eq(tag, 64'(b), 64'(e));
        end
        got_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic enc_pulse(input logic step, input logic dir, input logic press);
        @(negedge clk);
        enc_step  = step;
        enc_dir   = dir;
        enc_press = press;
        @(negedge clk);
        enc_step  = 1'b0;
        enc_press = 1'b0;
    endtask

    initial begin : main
        int budget;
        rst_n = 1'b0; rx_data = 8'h00; new_rx_data = 1'b0;
        enc_step = 1'b0; enc_dir = 1'b0; enc_press = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_freq", freq, {RW, RW});
        check_eq("rst_mode", 64'(mode), 64'd0);
        check_eq("rst_sel", 64'(sel_ch), 64'd0);
        check_eq("rst_txd", 64'(tx_data), 64'd0);
        check_eq("rst_ntx", 64'(new_tx_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send_str("f100"); send_byte(8'h0D); expect_resp("f100", "K");
        check_eq("f100_ch0", 64'(freq[31:0]), 64'd100);
        check_eq("f100_ch1", 64'(freq[63:32]), 64'(RW));

        send_str("c1"); expect_resp("c1", "K");
        check_eq("c1_sel", 64'(sel_ch), 64'd1);
        send_str("f4294967280"); send_byte(8'h0D); expect_resp("f_fff0", "K");
        check_eq("ch1_fff0", 64'(freq[63:32]), 64'hFFFF_FFF0);
        send_str("d"); expect_resp("d_sat", "K");
        check_eq("d_sat_ch1", 64'(freq[63:32]), 64'hFFFF_FFFF);
        check_eq("d_sat_ch0", 64'(freq[31:0]), 64'd100);
        send_str("-"); expect_resp("up_sat", "K");
        check_eq("up_sat_ch1", 64'(freq[63:32]), 64'hFFFF_FFFF);
        send_str("u"); expect_resp("u_half", "K");
        check_eq("u_half_ch1", 64'(freq[63:32]), 64'h7FFF_FFFF);

        send_str("c5"); expect_resp("c5", "E");
        check_eq("c5_sel", 64'(sel_ch), 64'd1);
        send_str("c2"); expect_resp("c2", "E");
        check_eq("c2_sel", 64'(sel_ch), 64'd1);
        send_str("c0"); expect_resp("c0", "K");
        check_eq("c0_sel", 64'(sel_ch), 64'd0);

        send_str("f12345678901"); send_byte(8'h0D); expect_resp("f11dig", "E");
        check_eq("f11dig_ch0", 64'(freq[31:0]), 64'd100);
        send_str("f4294967296"); send_byte(8'h0D); expect_resp("f_ovf", "E");
        check_eq("f_ovf_ch0", 64'(freq[31:0]), 64'd100);
        send_str("f0"); send_byte(8'h0D); expect_resp("f_zero", "E");
        check_eq("f_zero_ch0", 64'(freq[31:0]), 64'd100);
        send_str("fx"); expect_resp("f_abort", "E");
        check_eq("f_abort_ch0", 64'(freq[31:0]), 64'd100);
        send_str("f4294967295"); send_byte(8'h0D); expect_resp("f_max", "K");
        check_eq("f_max_ch0", 64'(freq[31:0]), 64'hFFFF_FFFF);

        send_str("r"); expect_resp("r", "K");
        check_eq("r_ch0", 64'(freq[31:0]), 64'(RW));
        send_str("="); expect_resp("dn", "K");
        check_eq("dn_ch0", 64'(freq[31:0]), 64'd2013266);
        send_str("-"); expect_resp("up", "K");
        check_eq("up_ch0", 64'(freq[31:0]), 64'd2139095);
        send_str("z"); expect_resp("bad_cmd", "E");
        send_str("t"); expect_resp("t", "K");
        check_eq("t_mode", 64'(mode), 64'h2);

        send_str("f1"); send_byte(8'h0D); expect_resp("f1", "K");
        send_str("="); expect_resp("dn_floor", "K");
        check_eq("dn_floor_ch0", 64'(freq[31:0]), 64'd1);
        send_str("u"); expect_resp("u_floor", "K");
        check_eq("u_floor_ch0", 64'(freq[31:0]), 64'd1);
        enc_pulse(1'b1, 1'b1, 1'b0); @(negedge clk);
        check_eq("enc_cw_floor", 64'(freq[31:0]), 64'd1);
        enc_pulse(1'b1, 1'b0, 1'b0); @(negedge clk);
        check_eq("enc_ccw", 64'(freq[31:0]), 64'd2);

        send_str("s"); expect_resp("s", "K");
        check_eq("s_mode", 64'(mode), 64'h0);
        repeat (3) enc_pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("press3_mode", 64'(mode), 64'h3);
        enc_pulse(1'b0, 1'b0, 1'b1); @(negedge clk);
        check_eq("press_wrap", 64'(mode), 64'h0);

        // byte arriving during RESP is dropped
        send_str("f5"); send_byte(8'h0D); send_byte(8'h64);
        expect_resp("f5", "K");
        check_eq("discard_ch0", 64'(freq[31:0]), 64'd5);
        repeat (20) @(negedge clk);
        check_eq("discard_noresp", 64'(got_q.size()), 64'd0);

        // encoder step on the APPLY cycle of "d" loses to the command
        send_byte(8'h64);
        enc_dir = 1'b0; enc_step = 1'b1;
        @(negedge clk);
        enc_step = 1'b0;
        expect_resp("enc_apply", "K");
        check_eq("enc_apply_ch0", 64'(freq[31:0]), 64'd10);

        send_str("r"); expect_resp("r2", "K");
        busy_cycles = 3;
        send_str("?");
`ifdef FG_READBACK_EN
        expect_resp("readback", "K0020C49B");
`else
        expect_resp("readback", "E");
`endif
        busy_cycles = 2;

        // reset while the third response byte is pending
        send_str("c1"); expect_resp("c1b", "K");
        send_str("t"); expect_resp("t1", "K");
        check_eq("t1_mode", 64'(mode), 64'h8);
        busy_cycles = 20;
        send_str("r");
        budget = 200;
        while (got_q.size() < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("abort_pre_cnt", 64'(got_q.size()), 64'd2);
        check_eq("abort_b0", 64'((got_q.size() > 0) ? got_q[0] : 8'h00), 64'h4B);
        check_eq("abort_b1", 64'((got_q.size() > 1) ? got_q[1] : 8'h00), 64'h0D);
        rst_n = 1'b0;
        #1;
        check_eq("abort_ntx", 64'(new_tx_data), 64'd0);
        check_eq("abort_txd", 64'(tx_data), 64'd0);
        check_eq("abort_freq", freq, {RW, RW});
        check_eq("abort_mode", 64'(mode), 64'd0);
        check_eq("abort_sel", 64'(sel_ch), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        busy_cycles = 2;
        repeat (60) @(negedge clk);
        check_eq("abort_post_cnt", 64'(got_q.size()), 64'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
